// File: rtl/pmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// pmem_arbiter_pkg : shared types and grant helper for the pmem arbiter
// Rev 1.0
// ============================================================================
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [127:0] lc3b_pmem_line;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic ARB_CLIENT_I = 1'b0;
  localparam logic ARB_CLIENT_D = 1'b1;

  localparam lc3b_pmem_addr LINE_ADDR_MASK = 16'hFFF0;

  // On a tie the round-robin rule hands the port to whoever did not have it last.
  function automatic logic pick_client(input logic req_i, input logic req_d,
                                       input logic last_grant, input logic rr_en);
    if (req_i && req_d) begin
      return rr_en ? ~last_grant : ARB_CLIENT_D;
    end
    return req_d ? ARB_CLIENT_D : ARB_CLIENT_I;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_arbiter_control.sv
`default_nettype none
// ============================================================================
// pmem_arbiter_control : IDLE/BUSY/DONE sequencer and grant selection
// Optional: PMEM_ARB_RR_EN enables round-robin grant on simultaneous requests.
// Rev 1.0
// ============================================================================
module pmem_arbiter_control
  import pmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic pmem_resp_i,
  output logic grant_o,
  output logic owner_o,
  output logic load_req_o,
  output logic busy_o
);

  arb_state_t state_q;
  logic       owner_q;
  logic       busy_q;
  logic       w_grant;

`ifdef PMEM_ARB_RR_EN
  logic last_grant_q;
  assign w_grant = pick_client(req_i_i, req_d_i, last_grant_q, 1'b1);
`else
  assign w_grant = pick_client(req_i_i, req_d_i, 1'b0, 1'b0);
`endif

  assign load_req_o = (state_q == ARB_IDLE) && (req_i_i || req_d_i);
  assign grant_o    = w_grant;
  assign owner_o    = owner_q;
  assign busy_o     = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_CLIENT_I;
      busy_q       <= 1'b0;
`ifdef PMEM_ARB_RR_EN
      last_grant_q <= ARB_CLIENT_I;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (load_req_o) begin
            state_q      <= ARB_BUSY;
            busy_q       <= 1'b1;
            owner_q      <= w_grant;
`ifdef PMEM_ARB_RR_EN
            last_grant_q <= w_grant;
`endif
          end
        end
        ARB_BUSY: begin
          if (pmem_resp_i) begin
            state_q <= ARB_DONE;
            busy_q  <= 1'b0;
          end
        end
        // One dead cycle lets the served cache retire its request before re-arbitration.
        ARB_DONE: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// pmem_arbiter : shares the physical-memory port between icache and dcache
// Optional: PMEM_ARB_RR_EN selects round-robin instead of dcache priority.
// Rev 1.0
// ============================================================================
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pmem_read,
  input  logic          i_pmem_write,
  input  lc3b_pmem_addr i_pmem_address,
  input  lc3b_pmem_line i_pmem_wdata,
  output logic          i_pmem_resp,
  output lc3b_pmem_line i_pmem_rdata,
  input  logic          d_pmem_read,
  input  logic          d_pmem_write,
  input  lc3b_pmem_addr d_pmem_address,
  input  lc3b_pmem_line d_pmem_wdata,
  output logic          d_pmem_resp,
  output lc3b_pmem_line d_pmem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_pmem_addr pmem_address,
  output lc3b_pmem_line pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_pmem_line pmem_rdata
);

  logic          w_req_i;
  logic          w_req_d;
  logic          w_grant;
  logic          w_owner;
  logic          w_load;
  logic          w_busy;
  logic          w_fire;

  logic          op_read_q,  op_read_d;
  logic          op_write_q, op_write_d;
  lc3b_pmem_addr addr_q,     addr_d;
  lc3b_pmem_line wdata_q,    wdata_d;

  assign w_req_i = i_pmem_read | i_pmem_write;
  assign w_req_d = d_pmem_read | d_pmem_write;

  pmem_arbiter_control u_control (
    .clk         (clk),
    .rst         (rst),
    .req_i_i     (w_req_i),
    .req_d_i     (w_req_d),
    .pmem_resp_i (pmem_resp),
    .grant_o     (w_grant),
    .owner_o     (w_owner),
    .load_req_o  (w_load),
    .busy_o      (w_busy)
  );

  // A client asserting both read and write is treated as a write.
  always_comb begin
    op_read_d  = op_read_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (w_load) begin
      if (w_grant == ARB_CLIENT_D) begin
        op_write_d = d_pmem_write;
        op_read_d  = d_pmem_read & ~d_pmem_write;
        addr_d     = d_pmem_address;
        wdata_d    = d_pmem_wdata;
      end else begin
        op_write_d = i_pmem_write;
        op_read_d  = i_pmem_read & ~i_pmem_write;
        addr_d     = i_pmem_address;
        wdata_d    = i_pmem_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      op_read_q  <= op_read_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign pmem_read    = w_busy & op_read_q;
  assign pmem_write   = w_busy & op_write_q;
  assign pmem_address = addr_q & LINE_ADDR_MASK;
  assign pmem_wdata   = wdata_q;

  assign w_fire       = w_busy & pmem_resp;
  assign i_pmem_resp  = w_fire & (w_owner == ARB_CLIENT_I);
  assign d_pmem_resp  = w_fire & (w_owner == ARB_CLIENT_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifndef SYNTHESIS
  a_single_op_i: assert property (@(posedge clk) disable iff (rst)
                   (NUM_CLIENTS == 2) && !(i_pmem_read && i_pmem_write));
  a_single_op_d: assert property (@(posedge clk) disable iff (rst)
                   !(d_pmem_read && d_pmem_write));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pmem_arbiter : randomized scoreboard bench for pmem_arbiter
// Rev 1.0
// ============================================================================
module tb_pmem_arbiter;

  typedef struct {
    bit           cl;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic [15:0]  i_pmem_address, d_pmem_address;
  logic [127:0] i_pmem_wdata, d_pmem_wdata;
  logic         i_pmem_resp, d_pmem_resp;
  logic [127:0] i_pmem_rdata, d_pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;

  int           n_checks = 0;
  int           n_fail   = 0;

  txn_t         exp_q[$];
  txn_t         cur;
  bit           cur_valid  = 1'b0;
  logic [127:0] mem_data   = '0;
  int           mem_lat    = 5;
  bit           use_fixed  = 1'b0;
  logic [127:0] fixed_data = '0;
  bit           last_grant = 1'b0;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_write   (i_pmem_write),
    .i_pmem_address (i_pmem_address),
    .i_pmem_wdata   (i_pmem_wdata),
    .i_pmem_resp    (i_pmem_resp),
    .i_pmem_rdata   (i_pmem_rdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_resp    (d_pmem_resp),
    .d_pmem_rdata   (d_pmem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit cl, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [127:0] w);
    if (cl) begin
      d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = w;
    end else begin
      i_pmem_read = rd; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = w;
    end
  endtask

  // Physical memory: captures each new transfer, then answers after mem_lat cycles.
  initial begin : memory
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_txn: got transfer to %h expected none", pmem_address);
            cur_valid = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            cur_valid = 1'b1;
            check("txn_write", pmem_write, cur.wr);
            check("txn_read",  pmem_read,  !cur.wr);
            check("txn_addr",  pmem_address, cur.addr & 16'hFFF0);
            check("txn_wdata", pmem_wdata, cur.wdata);
          end
          cnt = mem_lat;
        end else if (cur_valid) begin
          check("busy_addr_stable",  pmem_address, cur.addr & 16'hFFF0);
          check("busy_wdata_stable", pmem_wdata, cur.wdata);
        end
        cnt--;
        if (cnt == 0) begin
          mem_data   = use_fixed ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
          pmem_rdata = mem_data;
          pmem_resp  = 1'b1;
        end
      end
    end
  end

  // Response monitor: every client resp must match the open transfer exactly once.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (i_pmem_resp || d_pmem_resp) begin
          check("resp_onehot", i_pmem_resp & d_pmem_resp, 1'b0);
          if (!cur_valid) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: got i=%0d d=%0d expected none", i_pmem_resp, d_pmem_resp);
          end else begin
            check("resp_owner_d", d_pmem_resp, cur.cl);
            check("resp_owner_i", i_pmem_resp, !cur.cl);
            check("resp_rdata", cur.cl ? d_pmem_rdata : i_pmem_rdata, mem_data);
            cur_valid = 1'b0;
          end
        end else if (pmem_resp) begin
          n_checks++; n_fail++;
          $display("FAIL missing_resp: got no client resp expected one");
        end
      end
    end
  end

  task automatic client_req(input bit cl, input bit wr, input logic [15:0] a,
                            input logic [127:0] w, input int hold, input bit scramble);
    bit got;
    bit scr_done;
    got = 1'b0;
    scr_done = 1'b0;
    drive(cl, !wr, wr, a, w);
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (cl ? d_pmem_resp : i_pmem_resp) begin
        got = 1'b1;
      end else if (scramble && !scr_done && cur_valid && cur.cl == cl) begin
        scr_done = 1'b1;
        drive(cl, !wr, wr, 16'hFFF0, ~w);
      end
    end
    check("resp_seen", got, 1'b1);
    @(posedge clk); #1;
    if (hold <= 1) drive(cl, 1'b0, 1'b0, a, w);
    @(negedge clk);
    check("done_quiet_rd", pmem_read, 1'b0);
    check("done_quiet_wr", pmem_write, 1'b0);
    @(posedge clk); #1;
    if (hold >= 2) drive(cl, 1'b0, 1'b0, a, w);
    @(negedge clk);
    check("idle_quiet_rd", pmem_read, 1'b0);
    check("idle_quiet_wr", pmem_write, 1'b0);
  endtask

  // Reference model: decides the grant order for one round from the arbitration rules.
  task automatic run_round(input bit use_i, input bit use_d, input bit wr_i, input bit wr_d,
                           input logic [15:0] a_i, input logic [15:0] a_d,
                           input logic [127:0] w_i, input logic [127:0] w_d,
                           input int hold_i, input int hold_d,
                           input bit scr_i, input bit scr_d);
    txn_t ti, td;
    bit   first_d;
    ti = '{cl: 1'b0, wr: wr_i, addr: a_i, wdata: w_i};
    td = '{cl: 1'b1, wr: wr_d, addr: a_d, wdata: w_d};
    if (use_i && use_d) begin
`ifdef PMEM_ARB_RR_EN
      first_d = (last_grant == 1'b0);
`else
      first_d = 1'b1;
`endif
      if (first_d) begin
        exp_q.push_back(td); exp_q.push_back(ti); last_grant = 1'b0;
      end else begin
        exp_q.push_back(ti); exp_q.push_back(td); last_grant = 1'b1;
      end
    end else if (use_i) begin
      exp_q.push_back(ti); last_grant = 1'b0;
    end else if (use_d) begin
      exp_q.push_back(td); last_grant = 1'b1;
    end
    fork
      begin if (use_i) client_req(1'b0, wr_i, a_i, w_i, hold_i, scr_i); end
      begin if (use_d) client_req(1'b1, wr_d, a_d, w_d, hold_d, scr_d); end
    join
    check("queue_drained", exp_q.size(), 0);
    check("txn_closed", cur_valid, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int mode;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pmem_read",  pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr",  pmem_address, 16'h0);
    check("rst_pmem_wdata", pmem_wdata, 128'h0);
    check("rst_i_resp",     i_pmem_resp, 1'b0);
    check("rst_d_resp",     d_pmem_resp, 1'b0);
    rst = 1'b0;

    // Simultaneous pairs: dcache first after reset, with a mid-transfer address change.
    mem_lat = 4;
    @(posedge clk); #1;
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h2000, {4{32'h1111_0040}},
              {4{32'h2222_2000}}, 1, 1, 1'b0, 1'b1);
    @(posedge clk); #1;
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h2000, {4{32'h3333_0040}},
              {4{32'h4444_2000}}, 2, 2, 1'b0, 1'b0);

    // Single icache read with fixed memory data and first-edge latency.
    mem_lat = 5;
    use_fixed = 1'b1;
    fixed_data = {16{8'hA5}};
    @(posedge clk); #1;
    fork
      run_round(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 128'h0, 128'h0, 2, 1, 1'b0, 1'b0);
      begin
        @(posedge clk); @(negedge clk);
        check("latency_read", pmem_read, 1'b1);
        check("latency_addr", pmem_address, 16'h1230);
      end
    join
    use_fixed = 1'b0;

    // Dcache write-back.
    @(posedge clk); #1;
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h8000, 128'h0, {4{32'hDEAD_BEEF}},
              1, 1, 1'b0, 1'b0);

    // Reset while BUSY aborts the transfer with no response.
    mem_lat = 20;
    @(posedge clk); #1;
    exp_q.push_back('{cl: 1'b0, wr: 1'b0, addr: 16'h1230, wdata: 128'h0});
    drive(1'b0, 1'b1, 1'b0, 16'h1230, 128'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy_read", pmem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_abort_read", pmem_read, 1'b0);
    check("rst_abort_addr", pmem_address, 16'h0);
    check("rst_abort_resp", i_pmem_resp, 1'b0);
    cur_valid = 1'b0;
    last_grant = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h1230, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", pmem_read, 1'b0);

    for (int r = 0; r < 40; r++) begin
      mode = int'($urandom_range(0, 2));
      mem_lat = int'($urandom_range(1, 6));
      @(posedge clk); #1;
      run_round(mode != 1, mode != 0, ($urandom % 4) == 0, 1'($urandom),
                16'($urandom), 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(1, 2)), int'($urandom_range(1, 2)),
                1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
